io_sequencer: RTL and testbench
===============================

# io_sequencer

Controller between the MIPS core's IN/OUT instructions and the 7-segment display unit. It stalls the core during IN instructions until the user confirms a switch value with a debounced push-button, and latches OUT data for display. It also decides, cycle by cycle, whether the shared display shows CPU output, live switch entry, or nothing. It drives the display unit's `num`, `output_flag` and `input_flag` inputs.

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, default 16. Number of consecutive stable synchronized key samples required to accept a press or a release. Legal range is 2..2^20.

**Ports**
- `clk`  in  1  System clock. All state changes on the rising edge.
- `reset`  in  1  Asynchronous, active-low reset.
- `halt`  in  1  Core halted (syscall exit). Level-sensitive, sampled on `clk`.
- `io_in_req`  in  1  Core is executing IN. Held high until `in_valid` is seen.
- `io_out_req`  in  1  Core is executing OUT. Single-cycle qualifier for `out_data`.
- `out_data`  in  32  Value written by OUT.
- `SW`  in  4  Raw user switches.
- `key_confirm`  in  1  Raw push-button, active-low (pressed = 0). Asynchronous to `clk`.
- `stall`  out  1  Freeze the core pipeline. Combinational from state and inputs.
- `in_data`  out  32  Captured switch value, zero-extended `{28'b0, SW}`.
- `in_valid`  out  1  One-cycle pulse: `in_data` is valid and the IN completes.
- `num`  out  32  Value presented to the display unit.
- `output_flag`  out  1  Display unit shows `num`.
- `input_flag`  out  1  Display unit shows live switches.

## Operation

**Synchronizer and debounce**
- `key_confirm` passes through a 2-flop synchronizer (`key_s`).
- A debounce counter counts consecutive edges on which `key_s` equals the target level for the current state (0 in IN_WAIT, 1 in IN_RELEASE).
- The counter clears on any mismatch and on every state change.
- The target is reached when the counter would reach `DEBOUNCE_CYCLES`.

**FSM states:** IDLE, IN_WAIT, IN_RELEASE, HALTED.

- **IDLE**
  - If `halt`: go to HALTED.
  - Else if `io_in_req` and not `in_valid`: go to IN_WAIT. Set `input_flag`=1, `output_flag`=0.
  - Else if `io_out_req`: set `num`←`out_data`, `output_flag`=1, `input_flag`=0. Stay in IDLE.
  - If `io_in_req` and `io_out_req` are both high, IN wins. OUT is not latched that cycle.
- **IN_WAIT**
  - Waits for a debounced press.
  - On the target edge: `in_data`←`{28'b0,SW}` and go to IN_RELEASE. `SW` is sampled on that same edge; it is not synchronized.
- **IN_RELEASE**
  - Waits for a debounced release.
  - On the target edge, all of the following happen together:
    - `in_valid`←1 for one cycle;
    - `num`←`in_data`;
    - `output_flag`=1, `input_flag`=0;
    - go to IDLE.
- **HALTED**
  - `output_flag`=0, `input_flag`=0, `stall`=1.
  - Left only by reset.

**`halt` in any state** forces HALTED on the next edge. A pending IN is abandoned and `in_valid` never pulses.

**`stall`** is high when any of the following holds:
- state is IN_WAIT, IN_RELEASE or HALTED;
- state is IDLE, `io_in_req`=1 and `in_valid`=0.

**OUT never stalls.**

**Reset values** (while `reset`=0):
- state IDLE;
- `num`=0, `in_data`=0;
- `in_valid`=0, `output_flag`=0, `input_flag`=0;
- synchronizer flops = 1, debounce counter = 0;
- `stall` evaluates combinationally (0 unless `io_in_req`).

**Reset asserted mid-IN** returns to IDLE immediately. No `in_valid` is produced and the captured value is discarded.

## Timing

- **OUT:** `out_data` is sampled on the edge where `io_out_req`=1. `num` and `output_flag` are valid the next cycle (1-cycle latency).
- **Press latency:** raw key held low, first sampled at edge k. `key_s`=0 from edge k+1. Capture happens at edge k+DEBOUNCE_CYCLES+1.
- **Release latency:** same rule. `in_valid` is high in the cycle after edge r+DEBOUNCE_CYCLES+1, where r is the first edge sampling the raw key high.
- **Glitches:** any key glitch shorter than `DEBOUNCE_CYCLES` synchronized samples is ignored.
- **Counter width:** `$clog2(DEBOUNCE_CYCLES+1)` bits. The counter saturates and never wraps.
- **IN back-to-back:** the core must drop `io_in_req` in the cycle `in_valid` is high. A new IN may be requested the following cycle.

## Test plan

1. **OUT path:** `DEBOUNCE_CYCLES`=4, reset released, pulse `io_out_req` with `out_data`=12345678. Required: `num`=12345678 and `output_flag`=1 the next cycle; `stall` stays 0 throughout.
2. **IN path:** `io_in_req`=1, `SW`=4'hA, key low from edge k.
   - `stall`=1 immediately.
   - `input_flag`=1 from edge 1.
   - `in_data`=10 after edge k+5.
   - Key high from edge r: `in_valid` is a single-cycle pulse after edge r+5, with `num`=10, `output_flag`=1, and `stall`=0 in that same cycle.
3. **Bounce rejection:** in IN_WAIT, toggle the key low 3 cycles / high 1 cycle, repeated 5 times. Required: no capture; capture only after 4 stable synchronized low samples.
4. **Simultaneous requests:** `io_in_req`=`io_out_req`=1 in IDLE. Required: state goes to IN_WAIT and `num` is unchanged; a subsequent OUT after `in_valid` latches normally.
5. **Abort:** `halt`=1 during IN_RELEASE. Required: HALTED next cycle, both flags 0, `stall`=1, and no `in_valid` ever.
6. **Reset mid-IN:** `reset` low mid-IN, asynchronously between edges. Required: immediately `num`=0, flags 0, `in_valid`=0; IDLE after release.

Source files
------------

// File: rtl/io_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : io_sequencer
// Brief    : Sequences MIPS IN/OUT instructions against the 7-segment display.
//            IN stalls the core until a debounced press/release confirms the
//            switch value. OUT latches data for display. Also selects what
//            the shared display shows.
// Revision : 1.0 - initial release
// ============================================================================
module io_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    input  logic        io_in_req,
    input  logic        io_out_req,
    input  logic [31:0] out_data,
    input  logic [3:0]  SW,
    input  logic        key_confirm,
    output logic        stall,
    output logic [31:0] in_data,
    output logic        in_valid,
    output logic [31:0] num,
    output logic        output_flag,
    output logic        input_flag
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_IN_WAIT    = 2'd1,
        S_IN_RELEASE = 2'd2,
        S_HALTED     = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_key_meta;
    logic               r_key_s;
    logic [c_CNT_W-1:0] r_db_cnt;
    logic [31:0]        r_num;
    logic [31:0]        r_in_data;
    logic               r_in_valid;
    logic               r_output_flag;
    logic               r_input_flag;

    logic               w_key_target;
    logic               w_key_match;
    logic               w_db_done;

    // Waiting for a press the key must read low; waiting for release, high.
    assign w_key_target = (r_state == S_IN_RELEASE);
    assign w_key_match  = (r_key_s == w_key_target);
    // This edge would be the DEBOUNCE_CYCLES-th consecutive matching sample.
    assign w_db_done    = w_key_match && (r_db_cnt == c_CNT_LAST);

    // Core is frozen while an IN is outstanding or after halt.
    assign stall = (r_state != S_IDLE) || (io_in_req && !r_in_valid);

    assign num         = r_num;
    assign in_data     = r_in_data;
    assign in_valid    = r_in_valid;
    assign output_flag = r_output_flag;
    assign input_flag  = r_input_flag;

    // Two-flop synchronizer for the asynchronous push-button (idle high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key_meta <= 1'b1;
            r_key_s    <= 1'b1;
        end else begin
            r_key_meta <= key_confirm;
            r_key_s    <= r_key_meta;
        end
    end

    // Sequencer FSM with debounce counter and registered display outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_db_cnt      <= '0;
            r_num         <= 32'd0;
            r_in_data     <= 32'd0;
            r_in_valid    <= 1'b0;
            r_output_flag <= 1'b0;
            r_input_flag  <= 1'b0;
        end else begin
            r_in_valid <= 1'b0;
            if (halt) begin
                // Halt overrides everything; a pending IN is dropped silently.
                r_state       <= S_HALTED;
                r_db_cnt      <= '0;
                r_output_flag <= 1'b0;
                r_input_flag  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_db_cnt <= '0;
                        if (io_in_req && !r_in_valid) begin
                            // IN has priority; a simultaneous OUT is not latched.
                            r_state       <= S_IN_WAIT;
                            r_input_flag  <= 1'b1;
                            r_output_flag <= 1'b0;
                        end else if (io_out_req) begin
                            r_num         <= out_data;
                            r_output_flag <= 1'b1;
                            r_input_flag  <= 1'b0;
                        end
                    end
                    S_IN_WAIT: begin
                        if (w_db_done) begin
                            r_in_data <= {28'd0, SW};
                            r_state   <= S_IN_RELEASE;
                            r_db_cnt  <= '0;
                        end else if (w_key_match) begin
                            if (r_db_cnt != c_CNT_MAX) begin
                                r_db_cnt <= r_db_cnt + 1'b1;
                            end
                        end else begin
                            r_db_cnt <= '0;
                        end
                    end
                    S_IN_RELEASE: begin
                        if (w_db_done) begin
                            r_in_valid    <= 1'b1;
                            r_num         <= r_in_data;
                            r_output_flag <= 1'b1;
                            r_input_flag  <= 1'b0;
                            r_state       <= S_IDLE;
                            r_db_cnt      <= '0;
                        end else if (w_key_match) begin
                            if (r_db_cnt != c_CNT_MAX) begin
                                r_db_cnt <= r_db_cnt + 1'b1;
                            end
                        end else begin
                            r_db_cnt <= '0;
                        end
                    end
                    S_HALTED: begin
                        r_db_cnt      <= '0;
                        r_output_flag <= 1'b0;
                        r_input_flag  <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_db_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_sequencer
// Brief    : Self-checking bench for io_sequencer: directed scenarios with
//            literal expectations plus randomized traffic compared every
//            cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_sequencer;

    localparam int D = 4;

    logic        clk         = 1'b0;
    logic        reset       = 1'b0;
    logic        halt        = 1'b0;
    logic        io_in_req   = 1'b0;
    logic        io_out_req  = 1'b0;
    logic [31:0] out_data    = 32'd0;
    logic [3:0]  SW          = 4'd0;
    logic        key_confirm = 1'b1;
    logic        stall;
    logic [31:0] in_data;
    logic        in_valid;
    logic [31:0] num;
    logic        output_flag;
    logic        input_flag;

    io_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .halt        (halt),
        .io_in_req   (io_in_req),
        .io_out_req  (io_out_req),
        .out_data    (out_data),
        .SW          (SW),
        .key_confirm (key_confirm),
        .stall       (stall),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .num         (num),
        .output_flag (output_flag),
        .input_flag  (input_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 awaiting press, 2 awaiting release, 3 halted
    int          m_phase;
    logic [31:0] m_num;
    logic [31:0] m_in_data;
    logic        m_in_valid;
    logic        m_of;
    logic        m_if;
    logic        m_ks;
    logic        m_nv;
    logic        rq[$];   // raw key samples still travelling through the sync
    logic        win[$];  // synchronized samples seen since entering the phase
    bit          model_ready = 1'b0;

    function automatic bit window_all(logic v);
        if (win.size() < D) return 1'b0;
        foreach (win[i]) if (win[i] !== v) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase     = 0;
            m_num       = 32'd0;
            m_in_data   = 32'd0;
            m_in_valid  = 1'b0;
            m_of        = 1'b0;
            m_if        = 1'b0;
            rq          = '{1'b1, 1'b1};
            win.delete();
            model_ready = 1'b1;
        end else begin
            m_ks = rq[0];
            void'(rq.pop_front());
            rq.push_back(key_confirm);
            m_nv = 1'b0;
            if (halt) begin
                m_phase = 3; m_of = 1'b0; m_if = 1'b0; win.delete();
            end else if (m_phase == 0) begin
                if (io_in_req && !m_in_valid) begin
                    m_phase = 1; m_if = 1'b1; m_of = 1'b0; win.delete();
                end else if (io_out_req) begin
                    m_num = out_data; m_of = 1'b1; m_if = 1'b0;
                end
            end else if (m_phase == 1 || m_phase == 2) begin
                win.push_back(m_ks);
                if (win.size() > D) void'(win.pop_front());
                if (m_phase == 1 && window_all(1'b0)) begin
                    m_in_data = {28'd0, SW}; m_phase = 2; win.delete();
                end else if (m_phase == 2 && window_all(1'b1)) begin
                    m_nv = 1'b1; m_num = m_in_data; m_of = 1'b1; m_if = 1'b0;
                    m_phase = 0; win.delete();
                end
            end
            m_in_valid = m_nv;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic exp_stall;
    always @(negedge clk) begin
        if (model_ready) begin
            exp_stall = (m_phase != 0) || (io_in_req && !m_in_valid);
            n_cmp++;
            if ({in_data, in_valid, num, output_flag, input_flag, stall} !==
                {m_in_data, m_in_valid, m_num, m_of, m_if, exp_stall}) begin
                n_bad++;
                if (n_bad < 40)
                    $display("FAIL model_cycle t=%0t got in_data=%h in_valid=%b num=%h of=%b if=%b stall=%b want in_data=%h in_valid=%b num=%h of=%b if=%b stall=%b",
                             $time, in_data, in_valid, num, output_flag, input_flag, stall,
                             m_in_data, m_in_valid, m_num, m_of, m_if, exp_stall);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    int hold     = 1;
    int rst_left = 0;
    int halt_age = 0;

    initial begin
        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk32("reset_num", num, 32'd0);
        chk32("reset_in_data", in_data, 32'd0);
        chk1("reset_of", output_flag, 1'b0);
        chk1("reset_if", input_flag, 1'b0);
        chk1("reset_in_valid", in_valid, 1'b0);
        chk1("reset_stall", stall, 1'b0);
        reset = 1'b1;
        wait_edge();

        // ---- OUT path ----
        io_out_req = 1'b1; out_data = 32'd12345678;
        #1 chk1("out_stall_req", stall, 1'b0);
        wait_edge();
        chk32("out_num", num, 32'd12345678);
        chk1("out_of", output_flag, 1'b1);
        chk1("out_stall_after", stall, 1'b0);
        io_out_req = 1'b0;

        // ---- IN path ----
        SW = 4'hA; io_in_req = 1'b1;
        #1 chk1("in_stall_immediate", stall, 1'b1);
        wait_edge();
        chk1("in_input_flag", input_flag, 1'b1);
        chk1("in_output_flag", output_flag, 1'b0);
        key_confirm = 1'b0;
        repeat (5) wait_edge();
        chk32("in_no_capture_early", in_data, 32'd0);
        wait_edge();
        chk32("in_capture", in_data, 32'd10);
        key_confirm = 1'b1;
        repeat (5) wait_edge();
        chk1("in_valid_not_early", in_valid, 1'b0);
        wait_edge();
        chk1("in_valid_pulse", in_valid, 1'b1);
        chk32("in_num", num, 32'd10);
        chk1("in_of", output_flag, 1'b1);
        chk1("in_if_clear", input_flag, 1'b0);
        chk1("in_stall_release", stall, 1'b0);
        io_in_req = 1'b0;
        wait_edge();
        chk1("in_valid_single", in_valid, 1'b0);

        // ---- bounce rejection ----
        SW = 4'h5; io_in_req = 1'b1;
        wait_edge();
        for (int i = 0; i < 5; i++) begin
            key_confirm = 1'b0;
            repeat (3) wait_edge();
            key_confirm = 1'b1;
            wait_edge();
        end
        chk32("bounce_no_capture", in_data, 32'd10);
        chk1("bounce_still_input", input_flag, 1'b1);
        key_confirm = 1'b0;
        repeat (5) wait_edge();
        chk32("bounce_stable_early", in_data, 32'd10);
        wait_edge();
        chk32("bounce_capture", in_data, 32'd5);
        key_confirm = 1'b1;
        repeat (6) wait_edge();
        chk1("bounce_in_valid", in_valid, 1'b1);
        chk32("bounce_num", num, 32'd5);
        io_in_req = 1'b0;
        wait_edge();

        // ---- simultaneous IN and OUT ----
        io_in_req = 1'b1; io_out_req = 1'b1; out_data = 32'hDEADBEEF;
        wait_edge();
        io_out_req = 1'b0;
        chk32("simul_num_unchanged", num, 32'd5);
        chk1("simul_input_flag", input_flag, 1'b1);
        chk1("simul_stall", stall, 1'b1);
        SW = 4'h3; key_confirm = 1'b0;
        repeat (6) wait_edge();
        chk32("simul_capture", in_data, 32'd3);
        key_confirm = 1'b1;
        repeat (6) wait_edge();
        chk1("simul_in_valid", in_valid, 1'b1);
        chk32("simul_in_num", num, 32'd3);
        io_in_req = 1'b0; io_out_req = 1'b1; out_data = 32'hCAFE0001;
        wait_edge();
        io_out_req = 1'b0;
        chk32("simul_out_after", num, 32'hCAFE0001);
        chk1("simul_out_of", output_flag, 1'b1);

        // ---- halt during IN_RELEASE ----
        io_in_req = 1'b1; SW = 4'h7;
        wait_edge();
        key_confirm = 1'b0;
        repeat (6) wait_edge();
        chk32("abort_capture", in_data, 32'd7);
        key_confirm = 1'b1;
        repeat (2) wait_edge();
        halt = 1'b1;
        wait_edge();
        chk1("abort_of", output_flag, 1'b0);
        chk1("abort_if", input_flag, 1'b0);
        chk1("abort_stall", stall, 1'b1);
        for (int i = 0; i < 12; i++) begin
            wait_edge();
            chk1("abort_no_in_valid", in_valid, 1'b0);
        end
        io_in_req = 1'b0;
        #1 chk1("halted_stall", stall, 1'b1);
        reset = 1'b0;
        #1 halt = 1'b0;
        wait_edge();
        reset = 1'b1;
        wait_edge();
        chk1("post_halt_stall", stall, 1'b0);

        // ---- reset mid-IN ----
        io_out_req = 1'b1; out_data = 32'h11112222;
        wait_edge();
        io_out_req = 1'b0; io_in_req = 1'b1; SW = 4'h9;
        wait_edge();
        key_confirm = 1'b0;
        repeat (6) wait_edge();
        key_confirm = 1'b1;
        repeat (2) wait_edge();
        #2 reset = 1'b0;
        #1;
        chk32("rst_mid_num", num, 32'd0);
        chk32("rst_mid_in_data", in_data, 32'd0);
        chk1("rst_mid_of", output_flag, 1'b0);
        chk1("rst_mid_if", input_flag, 1'b0);
        chk1("rst_mid_in_valid", in_valid, 1'b0);
        io_in_req = 1'b0;
        #1 chk1("rst_mid_stall", stall, 1'b0);
        repeat (2) wait_edge();
        reset = 1'b1;
        wait_edge();
        chk1("rst_idle_if", input_flag, 1'b0);
        chk1("rst_idle_stall", stall, 1'b0);

        // ---- randomized traffic ----
        for (int cyc = 0; cyc < 4000; cyc++) begin
            wait_edge();
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) reset = 1'b1;
            end else if (halt) begin
                halt_age++;
                if (halt_age > 12) begin
                    halt = 1'b0; halt_age = 0;
                    reset = 1'b0; rst_left = 2; io_in_req = 1'b0;
                end
            end else if ($urandom_range(0, 799) == 0) begin
                #1 reset = 1'b0;
                rst_left = 2; io_in_req = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                halt = 1'b1;
            end
            if (io_in_req && in_valid)
                io_in_req = 1'b0;
            else if (!io_in_req && reset && !halt && $urandom_range(0, 9) == 0)
                io_in_req = 1'b1;
            io_out_req = ($urandom_range(0, 3) == 0);
            out_data   = $urandom;
            SW         = 4'($urandom_range(0, 15));
            hold--;
            if (hold <= 0) begin
                key_confirm = ~key_confirm;
                hold = int'($urandom_range(1, 9));
            end
        end

        repeat (3) wait_edge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
